sdiv_8bit: RTL and testbench

SDIV_8BIT -- requirements
Module: sdiv_8bit

---
 rtl/sdiv_pkg.sv | 12 +
 rtl/sdiv_8bit_twos_neg.sv | 12 +
 rtl/sdiv_8bit.sv | 167 ++++++++++++++++
 tb/tb_sdiv_8bit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sdiv_pkg.sv
// Shared width default and FSM state encoding for the sequential signed divider.
package sdiv_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sdiv_8bit_twos_neg.sv
// Conditional two's-complement negate on a (W+1)-bit magnitude-wide word.
module twos_neg #(
  parameter int W = 8
) (
  input  logic [W:0] a_i,
  input  logic       neg_i,
  output logic [W:0] y_o
);

  assign y_o = neg_i ? (~a_i + (W+1)'(1)) : a_i;

endmodule

// File: rtl/sdiv_8bit.sv
// Signed restoring divider: one quotient bit per cycle, fixed W+1 edge latency
// from start acceptance to the done pulse, with div-by-zero and overflow flags.
module sdiv_8bit
  import sdiv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] dividend,
  input  logic signed [W-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] quotient,
  output logic signed [W-1:0] remainder,
  output logic                div_by_zero,
  output logic                ovf
);

  localparam logic [W-1:0] CNT_LAST = W'(W - 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_e state_q, state_d;
  logic [W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]        quo_q, quo_d;
  logic [W:0]          rem_q, rem_d;
  logic [W:0]          dvs_q, dvs_d;
  logic [W-1:0]        orig_q, orig_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                dz_q, dz_d;
  logic                ov_q, ov_d;
  logic signed [W-1:0] quotient_q, quotient_d;
  logic signed [W-1:0] remainder_q, remainder_d;
  logic                dz_out_q, dz_out_d;
  logic                ovf_out_q, ovf_out_d;
  logic                done_q, done_d;

  logic [W:0]   dvd_abs, dvs_abs, q_fix, r_fix;
  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic         ge;

  twos_neg #(.W(W)) u_abs_dvd (
    .a_i   ({dividend[W-1], dividend}),
    .neg_i (dividend[W-1]),
    .y_o   (dvd_abs)
  );

  twos_neg #(.W(W)) u_abs_dvs (
    .a_i   ({divisor[W-1], divisor}),
    .neg_i (divisor[W-1]),
    .y_o   (dvs_abs)
  );

  twos_neg #(.W(W)) u_fix_quo (
    .a_i   ({1'b0, quo_q}),
    .neg_i (qneg_q),
    .y_o   (q_fix)
  );

  twos_neg #(.W(W)) u_fix_rem (
    .a_i   (rem_q),
    .neg_i (rneg_q),
    .y_o   (r_fix)
  );

  // Restoring step: bring in the next dividend bit, keep the difference if it did not borrow.
  assign shifted = {rem_q[W-1:0], quo_q[W-1]};
  assign diff    = {1'b0, shifted} - {1'b0, dvs_q};
  assign ge      = ~diff[W+1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    orig_d      = orig_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_out_d    = dz_out_q;
    ovf_out_d   = ovf_out_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // |dividend| never exceeds 2^(W-1), so its low W bits seed the shift register.
          quo_d   = dvd_abs[W-1:0];
          rem_d   = '0;
          dvs_d   = dvs_abs;
          orig_d  = dividend;
          qneg_d  = dividend[W-1] ^ divisor[W-1];
          rneg_d  = dividend[W-1];
          dz_d    = (divisor == '0);
          ov_d    = (dividend == MOST_NEG) && (divisor == '1);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        quo_d = {quo_q[W-2:0], ge};
        rem_d = ge ? diff[W:0] : shifted;
        cnt_d = cnt_q + W'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        quotient_d  = dz_q ? '1 : q_fix[W-1:0];
        remainder_d = dz_q ? orig_q : r_fix[W-1:0];
        dz_out_d    = dz_q;
        ovf_out_d   = ov_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      orig_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_out_q    <= 1'b0;
      ovf_out_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      orig_q      <= orig_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_out_q    <= dz_out_d;
      ovf_out_q   <= ovf_out_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_out_q;
  assign ovf         = ovf_out_q;

endmodule

// File: tb/tb_sdiv_8bit.sv
// Directed bench for sdiv_8bit: latency, signed results, special cases, start-while-busy, reset abort.
module tb_sdiv_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, ovf;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  sdiv_8bit #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eov);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, ".busy"}, busy, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, ".latency"}, lat, 9);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".div_by_zero"}, div_by_zero, edz);
    check({tag, ".ovf"}, ovf, eov);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".quotient_hold"}, quotient, eq);
  endtask

  initial begin
    int ndone;
    #2;
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.quotient", quotient, 8'h00);
    check("reset.remainder", remainder, 8'h00);
    check("reset.flags", {div_by_zero, ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("100/7",    8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0);
    run_op("-100/7",   8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0);
    run_op("100/-7",   8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0);
    run_op("-100/-7",  8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0);
    run_op("-128/-1",  8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1);
    run_op("-128/1",   8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0);
    run_op("5/0",      8'd5,   8'h00,  8'hFF, 8'h05, 1'b1, 1'b0);
    run_op("-5/0",     8'hFB,  8'h00,  8'hFF, 8'hFB, 1'b1, 1'b0);
    run_op("127/-128", 8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0);
    run_op("-128/-128",8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0);

    // start asserted mid-operation must be ignored
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("busy_start.done_count", ndone, 1);
    check("busy_start.quotient", quotient, 8'h0E);
    check("busy_start.remainder", remainder, 8'h02);

    // reset during CALC aborts the operation
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 1'b0);
    check("abort.quotient", quotient, 8'h00);
    check("abort.remainder", remainder, 8'h00);
    check("abort.flags", {done, div_by_zero, ovf}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort.no_done", ndone, 0);
    check("abort.idle", busy, 1'b0);

    run_op("9/3", 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
